// File: rtl/whole_system_ctrl.sv
// -----------------------------------------------------------------------------
// whole_system_ctrl
// Queued command sequencer. Commands {addr1, addr2, dest, op} are pushed into
// a small FIFO. A five-state FSM pops one command at a time, fetches two 4-bit
// operands from an external ROM, applies the operation and writes the 8-bit
// result into an external register file.
//
// Ports
//   clk                  system clock, rising-edge
//   rst                  asynchronous reset, active low
//   cmd_valid/cmd_ready  command handshake (push when both are 1)
//   cmd_addr1/2          ROM addresses of operands A and B
//   cmd_dest             register-file destination
//   cmd_op               00 add, 01 sub, 10 mul, 11 pass A
//   rom_addr/rom_data    ROM read port (data combinational from address)
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   result               last value written
//   busy                 FSM not in IDLE
//   done                 one-cycle pulse in the WRITE cycle
// -----------------------------------------------------------------------------
module whole_system_ctrl #(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_addr1,
  input  logic [2:0] cmd_addr2,
  input  logic [2:0] cmd_dest,
  input  logic [1:0] cmd_op,
  output logic [2:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic [7:0] result,
  output logic       busy,
  output logic       done
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

  typedef struct packed {
    logic [2:0] addr1;
    logic [2:0] addr2;
    logic [2:0] dest;
    logic [1:0] op;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    EXEC    = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  cmd_t            fifo_q [QDEPTH];
  cmd_t            fifo_d [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  cmd_t            cur_q, cur_d;
  logic [3:0]      opa_q, opa_d;
  logic [3:0]      opb_q, opb_d;
  logic [7:0]      result_q, result_d;

  logic            full;
  logic            pop;
  logic            push;
  logic [7:0]      a8;
  logic [7:0]      b8;
  logic [7:0]      alu;

  // A pop only depends on FSM state and occupancy, never on cmd_valid, so
  // letting it open cmd_ready when full creates no combinational loop. This
  // is what allows a push to land on the same edge that frees the slot.
  always_comb begin
    full      = (count_q == CNT_FULL);
    pop       = (state_q == IDLE) && (count_q != '0);
    cmd_ready = !full || pop;
    push      = cmd_valid && cmd_ready;
  end

  always_comb begin
    a8 = {4'b0000, opa_q};
    b8 = {4'b0000, opb_q};
    unique case (cur_q.op)
      2'b00:   alu = a8 + b8;
      2'b01:   alu = a8 - b8;
      2'b10:   alu = a8 * b8;
      default: alu = a8;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr1: cmd_addr1, addr2: cmd_addr2, dest: cmd_dest, op: cmd_op};
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    rom_addr = 3'd0;
    rf_we    = 1'b0;
    rf_waddr = 3'd0;
    rf_wdata = 8'd0;
    done     = 1'b0;
    busy     = (state_q != IDLE);
    result   = result_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cur_d   = fifo_q[rd_ptr_q];
          state_d = FETCH_A;
        end
      end
      FETCH_A: begin
        rom_addr = cur_q.addr1;
        opa_d    = rom_data;
        state_d  = FETCH_B;
      end
      FETCH_B: begin
        rom_addr = cur_q.addr2;
        opb_d    = rom_data;
        state_d  = EXEC;
      end
      EXEC: begin
        result_d = alu;
        state_d  = WRITE;
      end
      WRITE: begin
        rf_we    = 1'b1;
        rf_waddr = cur_q.dest;
        rf_wdata = result_q;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_whole_system_ctrl.sv
module tb_whole_system_ctrl;

  localparam int QDEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr1;
  logic [2:0] cmd_addr2;
  logic [2:0] cmd_dest;
  logic [1:0] cmd_op;
  logic [2:0] rom_addr;
  logic [3:0] rom_data;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] result;
  logic       busy;
  logic       done;

  logic [3:0] rom [8];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  whole_system_ctrl #(.QDEPTH(QDEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr1 (cmd_addr1),
    .cmd_addr2 (cmd_addr2),
    .cmd_dest  (cmd_dest),
    .cmd_op    (cmd_op),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] d;
    logic [1:0] op;
  } mcmd_t;

  // Reference model: timeline of the command being executed plus a queue.
  mcmd_t      q [$];
  mcmd_t      cur;
  int         cyc;
  int         pop_cyc;
  int         next_free;
  logic [7:0] cur_val;
  logic [7:0] res_exp;
  logic       m_pop;
  logic       m_ready;
  logic       m_acc;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] alu_model(input int a, input int b, input logic [1:0] op);
    int r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = (a - b + 256) % 256;
      2'b10:   r = a * b;
      default: r = a;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pop_cyc   = -100;
    next_free = 0;
    res_exp   = 8'd0;
    cur       = '0;
    cur_val   = 8'd0;
    m_acc     = 1'b0;
  endtask

  task automatic check_outputs();
    logic       e_busy, e_we, e_ready;
    logic [2:0] e_waddr, e_raddr;
    logic [7:0] e_wdata, e_res;
    if (!rst) begin
      m_pop   = 1'b0;
      m_ready = 1'b0;
      e_ready = 1'b1;
      e_busy  = 1'b0;
      e_we    = 1'b0;
      e_waddr = 3'd0;
      e_wdata = 8'd0;
      e_res   = 8'd0;
      e_raddr = 3'd0;
    end else begin
      m_pop   = (cyc >= next_free) && (q.size() > 0);
      m_ready = (q.size() < QDEPTH) || m_pop;
      e_ready = m_ready;
      e_busy  = (cyc < next_free);
      e_we    = (cyc == pop_cyc + 4);
      e_waddr = e_we ? cur.d : 3'd0;
      e_wdata = e_we ? cur_val : 8'd0;
      e_res   = res_exp;
      e_raddr = (cyc == pop_cyc + 1) ? cur.a1 : (cyc == pop_cyc + 2) ? cur.a2 : 3'd0;
    end
    chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, e_ready});
    chk("busy",      {7'd0, busy},      {7'd0, e_busy});
    chk("rf_we",     {7'd0, rf_we},     {7'd0, e_we});
    chk("done",      {7'd0, done},      {7'd0, e_we});
    chk("rf_waddr",  {5'd0, rf_waddr},  {5'd0, e_waddr});
    chk("rf_wdata",  rf_wdata,          e_wdata);
    chk("result",    result,            e_res);
    chk("rom_addr",  {5'd0, rom_addr},  {5'd0, e_raddr});
  endtask

  task automatic model_edge();
    m_acc = 1'b0;
    if (!rst) begin
      model_reset();
    end else begin
      if (cyc == pop_cyc + 3) res_exp = cur_val;
      if (m_pop) begin
        cur       = q.pop_front();
        pop_cyc   = cyc;
        next_free = cyc + 5;
        cur_val   = alu_model(int'(rom[cur.a1]), int'(rom[cur.a2]), cur.op);
      end
      if (cmd_valid && m_ready) begin
        q.push_back('{a1: cmd_addr1, a2: cmd_addr2, d: cmd_dest, op: cmd_op});
        m_acc = 1'b1;
      end
    end
    cyc++;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge,
  // return 1 time unit after it so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] a1, input logic [2:0] a2,
                          input logic [2:0] d, input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_addr1 = a1;
    cmd_addr2 = a2;
    cmd_dest  = d;
    cmd_op    = op;
    for (int k = 0; k < 40; k++) begin
      step();
      if (m_acc) begin
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    errors++;
    $error("FAIL push_timeout observed no accept expected accept within 40 cycles");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0 && cyc >= next_free) return;
      step();
    end
    checks++;
    errors++;
    $error("FAIL drain_timeout observed busy expected idle within 200 cycles");
  endtask

  initial begin
    cyc       = 0;
    model_reset();
    m_pop     = 1'b0;
    m_ready   = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 4'(i + 3);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr1 = 3'd0;
    cmd_addr2 = 3'd0;
    cmd_dest  = 3'd0;
    cmd_op    = 2'd0;

    // reset values before any clock edge
    #2;
    check_outputs();
    step();
    step();
    rst = 1'b1;
    step();

    // single add: 8 + 1 -> 9 into dest 0
    rom[4] = 4'd8;
    rom[5] = 4'd1;
    push_cmd(3'd4, 3'd5, 3'd0, 2'b00);
    wait_idle();
    chk("add_result", result, 8'd9);

    // sub wrap and mul back to back
    rom[1] = 4'd12;
    rom[3] = 4'd7;
    push_cmd(3'd3, 3'd1, 3'd2, 2'b01);
    push_cmd(3'd1, 3'd3, 3'd1, 2'b10);
    wait_idle();
    chk("mul_result", result, 8'd84);

    // three back-to-back pushes into a depth-2 queue, then a fourth that
    // must land on the pop edge while the queue is full
    push_cmd(3'd0, 3'd1, 3'd3, 2'b00);
    push_cmd(3'd2, 3'd3, 3'd4, 2'b01);
    push_cmd(3'd4, 3'd5, 3'd5, 2'b10);
    push_cmd(3'd6, 3'd7, 3'd6, 2'b11);
    wait_idle();

    // pass op: addr1 changes right after the push
    rom[2] = 4'd13;
    rom[6] = 4'd5;
    push_cmd(3'd2, 3'd0, 3'd7, 2'b11);
    cmd_addr1 = 3'd6;
    step();
    wait_idle();
    chk("pass_result", result, 8'd13);

    // randomized traffic
    for (int i = 0; i < 8; i++) rom[i] = 4'($urandom_range(0, 15));
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      push_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    wait_idle();

    // reset while in FETCH_B with one command still queued
    push_cmd(3'd1, 3'd2, 3'd3, 2'b00);
    push_cmd(3'd4, 3'd5, 3'd6, 2'b10);
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 1 && cyc == pop_cyc + 2) break;
      step();
    end
    chk("in_fetch_b", {7'd0, busy}, 8'd1);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_operand_a", {4'd0, dut.opa_q}, 8'd0);
    chk("rst_operand_b", {4'd0, dut.opb_q}, 8'd0);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) step();

    // operation resumes after reset release
    rom[0] = 4'd15;
    rom[7] = 4'd15;
    push_cmd(3'd0, 3'd7, 3'd1, 2'b10);
    wait_idle();
    chk("post_rst_mul", result, 8'd225);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
